// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and legality helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeB = 2'b00,
        SizeH = 2'b01,
        SizeW = 2'b10,
        SizeD = 2'b11
    } mem_size_e;

    localparam logic [2:0] LoadByte    = 3'b000;
    localparam logic [2:0] LoadHalf    = 3'b001;
    localparam logic [2:0] LoadWord    = 3'b010;
    localparam logic [2:0] LoadDouble  = 3'b011;
    localparam logic [2:0] LoadByteU   = 3'b100;
    localparam logic [2:0] LoadHalfU   = 3'b101;
    localparam logic [2:0] LoadWordU   = 3'b110;
    localparam logic [2:0] StoreByte   = 3'b000;
    localparam logic [2:0] StoreHalf   = 3'b001;
    localparam logic [2:0] StoreWord   = 3'b010;
    localparam logic [2:0] StoreDouble = 3'b011;

    typedef enum logic [1:0] {
        LsuIdle = 2'b00,
        LsuReq  = 2'b01,
        LsuWait = 2'b10,
        LsuResp = 2'b11
    } lsu_state_e;

    // True when the op is unsupported for this XLEN or its address is not naturally aligned.
    function automatic logic op_illegal(input logic we, input logic [2:0] funct3,
                                        input logic [2:0] addr_lo, input int xlen);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (funct3)
                StoreByte, StoreHalf, StoreWord: ok = 1'b1;
                StoreDouble:                     ok = (xlen == 64);
                default:                         ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                LoadByte, LoadHalf, LoadWord, LoadByteU, LoadHalfU: ok = 1'b1;
                LoadDouble, LoadWordU:                              ok = (xlen == 64);
                default:                                            ok = 1'b0;
            endcase
        end
        case (mem_size_e'(funct3[1:0]))
            SizeH:   if (addr_lo[0])           ok = 1'b0;
            SizeW:   if (addr_lo[1:0] != 2'b0) ok = 1'b0;
            SizeD:   if (addr_lo != 3'b0)      ok = 1'b0;
            default: ;
        endcase
        return !ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts a full bus word down by byte offset and sign/zero-extends to XLEN
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            rdata,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            data
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;

    // Mask down to the access size, then fill the upper bits with the sign bit unless unsigned.
    always_comb begin
        sh   = rdata >> {offset, 3'b000};
        mask = '1;
        sign = sh[XLEN-1];
        case (mem_size_e'(funct3[1:0]))
            SizeB: begin mask = XLEN'(8'hFF);          sign = sh[7];  end
            SizeH: begin mask = XLEN'(16'hFFFF);       sign = sh[15]; end
            SizeW: begin mask = XLEN'(32'hFFFF_FFFF);  sign = sh[31]; end
            default: ;
        endcase
        data = (sh & mask) | ((sign && !funct3[2]) ? ~mask : '0);
    end

endmodule

// File: rtl/load_store_unit_hs.sv
// rtl/load_store_unit_hs.sv - handshaked multi-cycle load/store unit driving a word-aligned memory bus
module load_store_unit_hs
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [2:0]          i_req_funct3,
    input  logic [XLEN-1:0]     i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    output logic                o_rsp_valid,
    output logic [XLEN-1:0]     o_rsp_data,
    output logic                o_rsp_err_misalign,
    output logic                o_rsp_err_bus,
    output logic                o_busy,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic                o_mem_we,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    output logic [XLEN-1:0]     o_mem_wdata,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata,
    input  logic                i_mem_err
);

    localparam int NB       = XLEN / 8;
    localparam int OFFW     = $clog2(NB);
    localparam int CNTW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNTW     = (CNTW_RAW < 1) ? 1 : CNTW_RAW;

    lsu_state_e      state_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            err_mis_q;
    logic            err_bus_q;

    logic [OFFW-1:0] off;
    logic [NB-1:0]   strb_base;
    logic [XLEN-1:0] load_data;
    logic            accept;
    logic            illegal;
    logic            timeout_hit;

    assign off         = addr_q[OFFW-1:0];
    assign accept      = i_req_valid && o_req_ready;
    assign illegal     = op_illegal(i_req_we, i_req_funct3, i_req_addr[2:0], XLEN);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNTW'(TIMEOUT_CYCLES));

    assign o_req_ready        = (state_q == LsuIdle) && !i_rst;
    assign o_busy             = (state_q != LsuIdle);
    assign o_rsp_valid        = (state_q == LsuResp);
    assign o_rsp_data         = rsp_data_q;
    assign o_rsp_err_misalign = err_mis_q;
    assign o_rsp_err_bus      = err_bus_q;

    // Bus side is driven straight from the captured request so it stays stable under backpressure.
    assign o_mem_valid = (state_q == LsuReq);
    assign o_mem_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign o_mem_we    = we_q;
    assign o_mem_wdata = wdata_q << {off, 3'b000};
    assign o_mem_wstrb = we_q ? (strb_base << off) : '0;

    // Byte-lane footprint of the access before shifting into position.
    always_comb begin
        strb_base = '0;
        case (mem_size_e'(funct3_q[1:0]))
            SizeB: strb_base = NB'(8'h01);
            SizeH: strb_base = NB'(8'h03);
            SizeW: strb_base = NB'(8'h0F);
            SizeD: strb_base = NB'(8'hFF);
            default: ;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (i_mem_rdata),
        .offset (off),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Request capture, bus sequencing, timeout and response registration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= LsuIdle;
            we_q       <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            err_mis_q  <= 1'b0;
            err_bus_q  <= 1'b0;
        end else begin
            case (state_q)
                LsuIdle: begin
                    if (accept) begin
                        we_q     <= i_req_we;
                        funct3_q <= i_req_funct3;
                        addr_q   <= i_req_addr;
                        wdata_q  <= i_req_wdata;
                        if (illegal) begin
                            rsp_data_q <= '0;
                            err_mis_q  <= 1'b1;
                            err_bus_q  <= 1'b0;
                            state_q    <= LsuResp;
                        end else begin
                            state_q <= LsuReq;
                        end
                    end
                end
                LsuReq: begin
                    if (i_mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= LsuWait;
                    end
                end
                LsuWait: begin
                    if (i_mem_rvalid) begin
                        rsp_data_q <= (we_q || i_mem_err) ? '0 : load_data;
                        err_mis_q  <= 1'b0;
                        err_bus_q  <= i_mem_err;
                        state_q    <= LsuResp;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        err_mis_q  <= 1'b0;
                        err_bus_q  <= 1'b1;
                        state_q    <= LsuResp;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                LsuResp: state_q <= LsuIdle;
                default: state_q <= LsuIdle;
            endcase
        end
    end

endmodule
